// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - lookup, update and clear signals of the branch predictor
// Ports (master = next-PC / resolve side, slave = predictor):
//   PF_PC, upd_en, upd_pc, upd_taken, upd_target, btb_clear : master -> slave
//   branch, target_addr, pred_hit                            : slave -> master
interface branch_predictor_if;
    logic [31:0] PF_PC;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        btb_clear;
    logic        branch;
    logic [31:0] target_addr;
    logic        pred_hit;

    modport master (
        output PF_PC, upd_en, upd_pc, upd_taken, upd_target, btb_clear,
        input  branch, target_addr, pred_hit
    );

    modport slave (
        input  PF_PC, upd_en, upd_pc, upd_taken, upd_target, btb_clear,
        output branch, target_addr, pred_hit
    );
endinterface

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with 2-bit saturating direction counters
// Ports:
//   clk : clock, all state changes on the rising edge
//   rst : synchronous active-high reset
//   bp  : branch_predictor_if.slave (combinational lookup of PF_PC, resolved-branch
//         update port, whole-table clear)
module branch_predictor #(
    parameter int IDX_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    branch_predictor_if.slave  bp
);
    localparam int N     = 1 << IDX_W;
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q [N];
    logic [TAG_W-1:0] tag_q   [N];
    logic [29:0]      tgt_q   [N];
    logic [1:0]       ctr_q   [N];

    // Lookup: purely combinational from PF_PC and the registered table
    logic [IDX_W-1:0] lk_idx;
    logic             lk_hit;

    always_comb begin
        lk_idx = bp.PF_PC[IDX_W+1:2];
        lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == bp.PF_PC[31:IDX_W+2])
                 && (bp.PF_PC[1:0] == 2'b00);
    end

    assign bp.pred_hit    = lk_hit;
    assign bp.branch      = lk_hit & ctr_q[lk_idx][1];
    assign bp.target_addr = (lk_hit & ctr_q[lk_idx][1]) ? {tgt_q[lk_idx], 2'b00} : 32'h0;

    // Update: compute the single entry write for this cycle
    logic [IDX_W-1:0] upd_idx;
    logic             upd_hit;
    logic             wr_en;
    logic [TAG_W-1:0] tag_d;
    logic [29:0]      tgt_d;
    logic [1:0]       ctr_d;

    always_comb begin
        upd_idx = bp.upd_pc[IDX_W+1:2];
        upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == bp.upd_pc[31:IDX_W+2]);
        wr_en   = 1'b0;
        tag_d   = tag_q[upd_idx];
        tgt_d   = tgt_q[upd_idx];
        ctr_d   = ctr_q[upd_idx];
        if (bp.upd_en && (bp.upd_pc[1:0] == 2'b00)) begin
            if (upd_hit) begin
                wr_en = 1'b1;
                if (bp.upd_taken) begin
                    ctr_d = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'd1;
                    tgt_d = bp.upd_target[31:2];
                end else begin
                    ctr_d = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'd1;
                end
            end else if (bp.upd_taken) begin
                // Allocate over whatever lives at this index, weakly taken
                wr_en = 1'b1;
                tag_d = bp.upd_pc[31:IDX_W+2];
                tgt_d = bp.upd_target[31:2];
                ctr_d = 2'b10;
            end
            // Not-taken miss leaves any aliased entry untouched
        end
    end

    // Targets are word aligned; the low bits carry no information
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^bp.upd_target[1:0];

    // Tag and target need no reset: valid=0 masks them
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b00;
            end
        end else if (bp.btb_clear) begin
            for (int i = 0; i < N; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (wr_en) begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= tag_d;
            tgt_q[upd_idx]   <= tgt_d;
            ctr_q[upd_idx]   <= ctr_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   pass_cnt = 0;
    int   fail_cnt = 0;
    int   total    = 0;

    branch_predictor_if bp_if ();

    branch_predictor #(.IDX_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input logic [31:0] pc);
        bp_if.PF_PC = pc;
        #1;
    endtask

    task automatic expect_pred(input string name, input logic [31:0] pc,
                               input logic hit, input logic br, input logic [31:0] tgt);
        look(pc);
        check({name, ".hit"},    32'(bp_if.pred_hit), 32'(hit));
        check({name, ".branch"}, 32'(bp_if.branch),   32'(br));
        check({name, ".target"}, bp_if.target_addr,   tgt);
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        bp_if.upd_en     = 1'b1;
        bp_if.upd_pc     = pc;
        bp_if.upd_taken  = taken;
        bp_if.upd_target = tgt;
        tick();
        bp_if.upd_en     = 1'b0;
    endtask

    initial begin
        bp_if.PF_PC      = 32'h0;
        bp_if.upd_en     = 1'b0;
        bp_if.upd_pc     = 32'h0;
        bp_if.upd_taken  = 1'b0;
        bp_if.upd_target = 32'h0;
        bp_if.btb_clear  = 1'b0;

        // 1. Reset for two cycles, then sweep
        tick();
        tick();
        expect_pred("in_reset", 32'hBFC0_0010, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            expect_pred("reset_sweep", 32'hBFC0_0000 + 32'(i * 4), 1'b0, 1'b0, 32'h0);
        end

        // 2. Allocate (ctr 10), strengthen (11), weaken twice (01)
        upd(32'hBFC0_0010, 1'b1, 32'hBFC0_0100);
        expect_pred("alloc", 32'hBFC0_0010, 1'b1, 1'b1, 32'hBFC0_0100);
        upd(32'hBFC0_0010, 1'b1, 32'hBFC0_0100);
        expect_pred("ctr11", 32'hBFC0_0010, 1'b1, 1'b1, 32'hBFC0_0100);
        upd(32'hBFC0_0010, 1'b0, 32'h0);
        expect_pred("ctr10", 32'hBFC0_0010, 1'b1, 1'b1, 32'hBFC0_0100);
        upd(32'hBFC0_0010, 1'b0, 32'h0);
        expect_pred("ctr01", 32'hBFC0_0010, 1'b1, 1'b0, 32'h0);

        // 3. Alias at idx 4: retrain 0x10 to ctr 10, then not-taken/taken at 0x50
        upd(32'hBFC0_0010, 1'b1, 32'hBFC0_0100);
        upd(32'hBFC0_0050, 1'b0, 32'h0);
        expect_pred("alias_nt_keep", 32'hBFC0_0010, 1'b1, 1'b1, 32'hBFC0_0100);
        expect_pred("alias_nt_miss", 32'hBFC0_0050, 1'b0, 1'b0, 32'h0);
        upd(32'hBFC0_0050, 1'b1, 32'hBFC0_0200);
        expect_pred("alias_evicted", 32'hBFC0_0010, 1'b0, 1'b0, 32'h0);
        expect_pred("alias_new",     32'hBFC0_0050, 1'b1, 1'b1, 32'hBFC0_0200);
        // ctr must be 10: one not-taken drops it below the taken threshold
        upd(32'hBFC0_0050, 1'b0, 32'h0);
        expect_pred("alias_ctr10", 32'hBFC0_0050, 1'b1, 1'b0, 32'h0);

        // 4. Same-cycle read and write to the same index: no bypass
        bp_if.PF_PC      = 32'hBFC0_0020;
        bp_if.upd_en     = 1'b1;
        bp_if.upd_pc     = 32'hBFC0_0020;
        bp_if.upd_taken  = 1'b1;
        bp_if.upd_target = 32'hBFC0_0300;
        #1;
        check("rw_same_hit",    32'(bp_if.pred_hit), 32'd0);
        check("rw_same_branch", 32'(bp_if.branch),   32'd0);
        tick();
        bp_if.upd_en = 1'b0;
        expect_pred("rw_next", 32'hBFC0_0020, 1'b1, 1'b1, 32'hBFC0_0300);

        // 5. Clear wins over a simultaneous update
        bp_if.btb_clear  = 1'b1;
        bp_if.upd_en     = 1'b1;
        bp_if.upd_pc     = 32'hBFC0_0030;
        bp_if.upd_taken  = 1'b1;
        bp_if.upd_target = 32'hBFC0_0400;
        tick();
        bp_if.btb_clear = 1'b0;
        bp_if.upd_en    = 1'b0;
        expect_pred("clr_upd_dropped", 32'hBFC0_0030, 1'b0, 1'b0, 32'h0);
        expect_pred("clr_old_50",      32'hBFC0_0050, 1'b0, 1'b0, 32'h0);
        expect_pred("clr_old_20",      32'hBFC0_0020, 1'b0, 1'b0, 32'h0);

        // 6. Misaligned lookup and updates
        upd(32'hBFC0_0010, 1'b1, 32'hBFC0_0100);
        expect_pred("mis_lookup", 32'hBFC0_0012, 1'b0, 1'b0, 32'h0);
        upd(32'hBFC0_0016, 1'b1, 32'hBFC0_0500);
        expect_pred("mis_upd_alloc", 32'hBFC0_0014, 1'b0, 1'b0, 32'h0);
        upd(32'hBFC0_0012, 1'b0, 32'h0);
        expect_pred("mis_upd_ctr", 32'hBFC0_0010, 1'b1, 1'b1, 32'hBFC0_0100);

        // Reset mid-training discards everything in one edge
        rst = 1'b1;
        tick();
        expect_pred("rst_during", 32'hBFC0_0010, 1'b0, 1'b0, 32'h0);
        rst = 1'b0;
        expect_pred("rst_after", 32'hBFC0_0010, 1'b0, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
